nested_isqrt_pipe: RTL and testbench
====================================

// Module: nested_isqrt_pipe
// PURPOSE
//  Fully pipelined evaluator of the nested square root
//  res = isqrt(arg[N-1] + isqrt(... + isqrt(arg[1] + isqrt(arg[0])))).
//  Each nesting level has one add stage followed by W/2 sqrt stages (one result bit per stage).
//  The whole pipeline has an output-driven valid/ready stall.
//  Generalised successor of the fixed 3-level, 32-bit formula pipe; sits between arithmetic producers and consumers.
// PARAMETERS
//  W  32  argument width; must be even, >= 4
//  N  3   nesting depth (number of arguments), >= 1
// PORTS
//  clk      in   1      clock, rising edge
//  rst_n    in   1      asynchronous reset, active-low
//  arg_vld  in   1      argument bundle valid
//  arg_rdy  out  1      pipeline accepts a bundle this cycle
//  args     in   N*W    packed arguments; args[k*W +: W] = arg[k]; arg[0] is innermost
//  res_vld  out  1      result valid
//  res_rdy  in   1      consumer accepts the result
//  res      out  W/2    floor square root result
//  res_sat  out  1      any level saturated (only with NESTED_ISQRT_SAT_EN)
// BEHAVIOUR
//  - Reset: asynchronous assert on rst_n low.
//    - All stage valids, res_vld, res and res_sat go to 0; data registers go to 0.
//    - Release is synchronous to clk.
//    - Reset mid-operation discards all in-flight bundles; no partial result emerges.
//  - Stage structure: level k (k = 0..N-1) has add stage A_k, then sqrt stages S_k,0 .. S_k,W/2-1.
//    - A_0 registers arg[0] (sum = arg[0] + 0).
//    - A_k, k > 0: sum = arg[k] + {0, root_{k-1}}, where root_{k-1} is the W/2-bit result of level k-1.
//    - S_k,j resolves root bit (W/2-1-j) by the restoring digit method; it carries remainder, partial root and radicand.
//    - Result is exact: root = floor(sqrt(sum)), with root^2 <= sum < (root+1)^2.
//  - Argument transport: arg[k] (k >= 1) travels unchanged in each bundle's stage registers until A_k consumes it.
//    - Registers for already-consumed args may be dropped.
//  - Latency: L = N*(1 + W/2) cycles from an accepted input (arg_vld & arg_rdy) to res_vld, when no stall occurs.
//    - W=32, N=3 gives L = 51.
//  - Throughput: one bundle per cycle.
//  - Handshake / stall:
//    - adv = ~res_vld | res_rdy.
//    - arg_rdy = adv. This is a combinational path from res_rdy.
//    - When adv = 1 all stages shift by one. When adv = 0 every stage, including the outputs, holds.
//    - A bubble (stage valid = 0) shifts like data; bubbles are not compressed.
//    - arg_vld & ~arg_rdy: the input is ignored; the producer must hold it.
//    - res, res_vld and res_sat stay stable while res_vld & ~res_rdy.
//  - Overflow: the add result at A_k can exceed 2^W-1 (at most (2^W-1) + (2^(W/2)-1)).
//    - Handling is set by the macro below. Level 0 never overflows.
// CONFIGURATION
//  - Macro NESTED_ISQRT_SAT_EN defined:
//    - The A_k sum saturates to 2^W-1.
//    - A sticky sat bit travels with each bundle and is set if any level saturated.
//    - res_sat presents that bit, qualified by res_vld (0 when res_vld = 0).
//  - Macro not defined:
//    - The sum wraps modulo 2^W (the carry is discarded).
//    - Port res_sat does not exist and no sat logic is built.
// TESTING
//  1. W=32, N=3, args {a=5, b=12, c=16}, rdy held 1 -> res=3, res_vld exactly 51 cycles after acceptance.
//  2. W=32, N=3, 200 back-to-back random bundles, res_rdy=1 -> one result per cycle, in order, each equal to the software model.
//  3. W=8, N=2, arg[0]=255, arg[1]=250 -> macro defined: res=15, res_sat=1; macro undefined: res=3 (265 mod 256 = 9).
//  4. Stall: res_rdy=0 for 10 cycles while res_vld=1 -> arg_rdy=0 and res is stable.
//     - On res_rdy=1 the stream resumes with no lost or duplicated bundle.
//  5. Reset asserted (rst_n=0) with 20 bundles in flight, released after 3 cycles -> outputs 0 immediately and no stale res_vld.
//     - Next accepted bundle appears after L cycles.
//  6. Edge values, W=16, N=1: arg=0 -> 0; arg=1 -> 1; arg=65535 -> 255; arg=65024 -> 254 (255^2 = 65025).

Source files
------------

// File: rtl/nested_isqrt_pipe.sv
// Pipelined nested floor square root: res = isqrt(arg[N-1] + ... isqrt(arg[1] + isqrt(arg[0]))).
// Define NESTED_ISQRT_SAT_EN for saturating level sums and the res_sat output; otherwise sums wrap.
module nested_isqrt_pipe #(
  parameter int W = 32,
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arg_vld,
  output logic             arg_rdy,
  input  logic [N*W-1:0]   args,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [W/2-1:0]   res
`ifdef NESTED_ISQRT_SAT_EN
  ,
  output logic             res_sat
`endif
);
  localparam int H = W / 2;

  logic adv;

`ifdef NESTED_ISQRT_SAT_EN
  function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [H-1:0] r);
    logic [W:0] s;
    s = {1'b0, a} + {{(W + 1 - H){1'b0}}, r};
    if (s[W]) s = {1'b1, {W{1'b1}}};
    return s;
  endfunction
`else
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input logic [H-1:0] r);
    return a + {{(W - H){1'b0}}, r};
  endfunction
`endif

  genvar k, j;
  for (k = 0; k < N; k++) begin : lvl
    logic           in_vld;
    logic [W-1:0]   in_arg;
    logic [H-1:0]   in_root;
    logic           a_vld_q;
    logic [W-1:0]   a_sum_q, a_sum_d;
`ifdef NESTED_ISQRT_SAT_EN
    logic           in_sat, a_sat_q, a_sat_d;
    logic [W:0]     add_res;
`endif

    if (k == 0) begin : src_in
      assign in_vld  = arg_vld;
      assign in_arg  = args[W-1:0];
      assign in_root = '0;
`ifdef NESTED_ISQRT_SAT_EN
      assign in_sat  = 1'b0;
`endif
    end else begin : src_prev
      assign in_vld  = lvl[k-1].stg[H-1].vld_q;
      assign in_arg  = lvl[k-1].stg[H-1].cy.args_q[W-1:0];
      assign in_root = lvl[k-1].stg[H-1].root_q;
`ifdef NESTED_ISQRT_SAT_EN
      assign in_sat  = lvl[k-1].stg[H-1].sat_q;
`endif
    end

`ifdef NESTED_ISQRT_SAT_EN
    assign add_res = sat_add(in_arg, in_root);
    assign a_sum_d = add_res[W-1:0];
    assign a_sat_d = add_res[W] | in_sat;
`else
    assign a_sum_d = wrap_add(in_arg, in_root);
`endif

    // add stage A_k
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_vld_q <= 1'b0;
        a_sum_q <= '0;
`ifdef NESTED_ISQRT_SAT_EN
        a_sat_q <= 1'b0;
`endif
      end else if (adv) begin
        a_vld_q <= in_vld;
        a_sum_q <= a_sum_d;
`ifdef NESTED_ISQRT_SAT_EN
        a_sat_q <= a_sat_d;
`endif
      end
    end

    // arguments still to be consumed by outer levels ride along with the bundle
    if (k < N - 1) begin : a_cy
      logic [(N-1-k)*W-1:0] args_q, args_d;
      if (k == 0) begin : from_in
        assign args_d = args[N*W-1:W];
      end else begin : from_prev
        assign args_d = lvl[k-1].stg[H-1].cy.args_q[(N-k)*W-1:W];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   args_q <= '0;
        else if (adv) args_q <= args_d;
      end
    end

    for (j = 0; j < H; j++) begin : stg
      logic           vin;
      logic [H:0]     rin;
      logic [H-1:0]   qin;
      logic [1:0]     dig;
      logic [H+2:0]   cur, trial;
      logic           ge;
      logic           vld_q;
      logic [H-1:0]   root_q, root_d;
`ifdef NESTED_ISQRT_SAT_EN
      logic           sin, sat_q;
`endif

      if (j == 0) begin : from_add
        assign vin = a_vld_q;
        assign rin = '0;
        assign qin = '0;
        assign dig = a_sum_q[W-1:W-2];
`ifdef NESTED_ISQRT_SAT_EN
        assign sin = a_sat_q;
`endif
      end else begin : from_stg
        assign vin = stg[j-1].vld_q;
        assign rin = stg[j-1].keep.rem_q;
        assign qin = stg[j-1].root_q;
        assign dig = stg[j-1].keep.rad_q[W-2*j-1:W-2*j-2];
`ifdef NESTED_ISQRT_SAT_EN
        assign sin = stg[j-1].sat_q;
`endif
      end

      // restoring digit: try appending 1 to the root, keep it if 4*q+1 fits in the remainder
      assign cur    = {rin, dig};
      assign trial  = {1'b0, qin, 2'b01};
      assign ge     = (cur >= trial);
      assign root_d = {qin[H-2:0], ge};

      // sqrt stage S_k,j
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q  <= 1'b0;
          root_q <= '0;
`ifdef NESTED_ISQRT_SAT_EN
          sat_q  <= 1'b0;
`endif
        end else if (adv) begin
          vld_q  <= vin;
          root_q <= root_d;
`ifdef NESTED_ISQRT_SAT_EN
          sat_q  <= sin;
`endif
        end
      end

      // remainder and unconsumed radicand bits are dead after the final digit
      if (j < H - 1) begin : keep
        logic [H:0]         rem_q, rem_d;
        logic [W-2*j-3:0]   rad_q, rad_d;
        assign rem_d = ge ? (cur[H:0] - trial[H:0]) : cur[H:0];
        if (j == 0) begin : rad_add
          assign rad_d = a_sum_q[W-3:0];
        end else begin : rad_stg
          assign rad_d = stg[j-1].keep.rad_q[W-2*j-3:0];
        end
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            rem_q <= '0;
            rad_q <= '0;
          end else if (adv) begin
            rem_q <= rem_d;
            rad_q <= rad_d;
          end
        end
      end

      if (k < N - 1) begin : cy
        logic [(N-1-k)*W-1:0] args_q, args_d;
        if (j == 0) begin : from_add_cy
          assign args_d = a_cy.args_q;
        end else begin : from_stg_cy
          assign args_d = stg[j-1].cy.args_q;
        end
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)   args_q <= '0;
          else if (adv) args_q <= args_d;
        end
      end
    end
  end

  assign res_vld = lvl[N-1].stg[H-1].vld_q;
  assign res     = lvl[N-1].stg[H-1].root_q;
  assign adv     = ~res_vld | res_rdy;
  assign arg_rdy = adv;
`ifdef NESTED_ISQRT_SAT_EN
  assign res_sat = res_vld & lvl[N-1].stg[H-1].sat_q;
`endif

endmodule

// File: tb/tb_nested_isqrt_pipe.sv
// Directed bench for nested_isqrt_pipe at (W=32,N=3), (W=8,N=2) and (W=16,N=1).
module tb_nested_isqrt_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_vld, a_rdy, a_rvld, a_rrdy;
  logic [95:0] a_args;
  logic [15:0] a_res;
  logic        b_vld, b_rdy, b_rvld, b_rrdy;
  logic [15:0] b_args;
  logic [3:0]  b_res;
  logic        c_vld, c_rdy, c_rvld, c_rrdy;
  logic [15:0] c_args;
  logic [7:0]  c_res;
`ifdef NESTED_ISQRT_SAT_EN
  logic        a_sat, b_sat, c_sat;
`endif

  int errs;
  int checks;

  nested_isqrt_pipe #(.W(32), .N(3)) u_a (
    .clk(clk), .rst_n(rst_n), .arg_vld(a_vld), .arg_rdy(a_rdy), .args(a_args),
    .res_vld(a_rvld), .res_rdy(a_rrdy), .res(a_res)
`ifdef NESTED_ISQRT_SAT_EN
    , .res_sat(a_sat)
`endif
  );
  nested_isqrt_pipe #(.W(8), .N(2)) u_b (
    .clk(clk), .rst_n(rst_n), .arg_vld(b_vld), .arg_rdy(b_rdy), .args(b_args),
    .res_vld(b_rvld), .res_rdy(b_rrdy), .res(b_res)
`ifdef NESTED_ISQRT_SAT_EN
    , .res_sat(b_sat)
`endif
  );
  nested_isqrt_pipe #(.W(16), .N(1)) u_c (
    .clk(clk), .rst_n(rst_n), .arg_vld(c_vld), .arg_rdy(c_rdy), .args(c_args),
    .res_vld(c_rvld), .res_rdy(c_rrdy), .res(c_res)
`ifdef NESTED_ISQRT_SAT_EN
    , .res_sat(c_sat)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint isq(longint x);
    longint r = 0;
    longint t;
    for (int b = 20; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  function automatic longint nest32(logic [95:0] a, output bit s);
    longint r = 0;
    longint v;
    s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v = longint'(a[k*32 +: 32]) + r;
      if (v > 64'h0000_0000_FFFF_FFFF) begin
`ifdef NESTED_ISQRT_SAT_EN
        v = 64'h0000_0000_FFFF_FFFF;
        s = 1'b1;
`else
        v = v - 64'h0000_0001_0000_0000;
`endif
      end
      r = isq(v);
    end
    return r;
  endfunction

  task automatic lat_a(input logic [95:0] v, input logic [15:0] exp, input string tag);
    int cyc;
    @(negedge clk);
    a_args = v; a_vld = 1'b1; a_rrdy = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1 a_vld = 1'b0;
    while (!a_rvld && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    chk({tag, "_lat"}, cyc, 51);
    chk({tag, "_res"}, a_res, exp);
`ifdef NESTED_ISQRT_SAT_EN
    chk({tag, "_sat"}, a_sat, 0);
`endif
    @(posedge clk);
    #1 chk({tag, "_drop"}, a_rvld, 0);
  endtask

  task automatic lat_b(input logic [15:0] v, input logic [3:0] exp, input logic es, input string tag);
    int cyc;
    @(negedge clk);
    b_args = v; b_vld = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1 b_vld = 1'b0;
    while (!b_rvld && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    chk({tag, "_lat"}, cyc, 10);
    chk({tag, "_res"}, b_res, exp);
`ifdef NESTED_ISQRT_SAT_EN
    chk({tag, "_sat"}, b_sat, es);
`else
    if (es) chk({tag, "_sat_cfg"}, b_rvld, 1);
`endif
  endtask

  task automatic lat_c(input logic [15:0] v, input logic [7:0] exp, input string tag);
    int cyc;
    @(negedge clk);
    c_args = v; c_vld = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1 c_vld = 1'b0;
    while (!c_rvld && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    chk({tag, "_lat"}, cyc, 9);
    chk({tag, "_res"}, c_res, exp);
  endtask

  // streams K bundles into the 32-bit DUT; optionally holds res_rdy low for
  // 'stall' cycles starting at the first valid result
  task automatic run_a(input int K, input int stall, input string tag);
    logic [95:0] v;
    logic [15:0] expq[$];
    bit          satq[$];
    bit          s;
    longint      e;
    int sent = 0, got = 0, stall_left = 0, cyc = 0;
    bit stalled = 1'b0;
    v = (stall == 0) ? {96{1'b1}} : {32'd5, 32'd12, 32'd16};
    while (got < K && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (stall > 0 && !stalled && a_rvld) begin
        stalled = 1'b1;
        stall_left = stall;
      end
      a_rrdy = (stall_left == 0);
      a_vld  = (sent < K);
      a_args = v;
      #1;
      if (stall_left > 0) begin
        chk({tag, "_rdy"}, a_rdy, 0);
        chk({tag, "_hold"}, a_res, expq[0]);
        stall_left--;
      end else if (a_rvld) begin
        if (expq.size() == 0) begin
          chk({tag, "_spur"}, a_rvld, 0);
        end else begin
          chk({tag, "_res"}, a_res, expq.pop_front());
`ifdef NESTED_ISQRT_SAT_EN
          chk({tag, "_sat"}, a_sat, satq.pop_front());
`else
          void'(satq.pop_front());
`endif
          got++;
        end
      end else if (stall == 0 && got > 0) begin
        chk({tag, "_gap"}, a_rvld, 1);
      end
      if (a_vld && a_rdy) begin
        e = nest32(v, s);
        expq.push_back(16'(e));
        satq.push_back(s);
        sent++;
        if (sent % 4 == 1) v = {32'(sent * sent), 32'(sent * 7), 32'(sent)};
        else               v = {$urandom(), $urandom(), $urandom()};
      end
    end
    chk({tag, "_count"}, got, K);
    @(negedge clk);
    a_vld = 1'b0;
    #1 chk({tag, "_tail"}, a_rvld, 0);
  endtask

  initial begin
    int cnt;
    errs = 0; checks = 0;
    rst_n = 1'b0;
    a_vld = 1'b0; a_rrdy = 1'b1; a_args = '0;
    b_vld = 1'b0; b_rrdy = 1'b1; b_args = '0;
    c_vld = 1'b0; c_rrdy = 1'b1; c_args = '0;
    repeat (3) @(negedge clk);
    chk("rst_vld", a_rvld, 0);
    chk("rst_res", a_res, 0);
    chk("rst_rdy", a_rdy, 1);
    rst_n = 1'b1;

    // arg0=16 -> 4; 12+4=16 -> 4; 5+4=9 -> 3
    lat_a({32'd5, 32'd12, 32'd16}, 16'd3, "t1");
    run_a(40, 0, "t2");
    run_a(20, 10, "t4");

    // reset with a full pipe and results emerging
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      a_vld = 1'b1;
      a_args = {32'(i + 100), 32'(i + 50), 32'(i + 1)};
    end
    @(negedge clk);
    a_vld = 1'b0;
    #1 chk("t5_pre_vld", a_rvld, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", a_rvld, 0);
    chk("t5_rst_res", a_res, 0);
`ifdef NESTED_ISQRT_SAT_EN
    chk("t5_rst_sat", a_sat, 0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // arg0=100 -> 10; 20+10=30 -> 5; 44+5=49 -> 7
    lat_a({32'd44, 32'd20, 32'd100}, 16'd7, "t5");
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (a_rvld) cnt++;
    end
    chk("t5_stale", cnt, 0);

    // 255 -> 15; 250+15=265 overflows 8 bits
`ifdef NESTED_ISQRT_SAT_EN
    lat_b({8'd250, 8'd255}, 4'd15, 1'b1, "t3_ovf");
`else
    lat_b({8'd250, 8'd255}, 4'd3, 1'b0, "t3_ovf");
`endif
    lat_b({8'd10, 8'd16}, 4'd3, 1'b0, "t3_norm");
    lat_b({8'd0, 8'd0}, 4'd0, 1'b0, "t3_zero");

    lat_c(16'd0,     8'd0,   "t6_0");
    lat_c(16'd1,     8'd1,   "t6_1");
    lat_c(16'd65535, 8'd255, "t6_max");
    lat_c(16'd65024, 8'd254, "t6_below");
    lat_c(16'd65025, 8'd255, "t6_square");
    lat_c(16'd3,     8'd1,   "t6_3");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
